// File: rtl/uart_slip_decoder_pkg.sv
// ---------------------------------------------------------------------------
// uart_slip_decoder_pkg
//   Shared SLIP (RFC 1055) framing codes and decoder state encoding.
//   Imported by uart_slip_decoder.
// ---------------------------------------------------------------------------
package uart_slip_decoder_pkg;

   // SLIP special characters
   localparam logic [7:0] SLIP_END     = 8'hC0;
   localparam logic [7:0] SLIP_ESC     = 8'hDB;
   localparam logic [7:0] SLIP_ESC_END = 8'hDC;
   localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

   // Width of the per-frame payload length counter (saturating)
   localparam int unsigned LEN_CNT_W = 16;

   // Decoder FSM: NORMAL = plain bytes, ESC = previous byte was SLIP_ESC
   typedef enum logic {
      STATE_NORMAL = 1'b0,
      STATE_ESC    = 1'b1
   } state_e;

endpackage : uart_slip_decoder_pkg

// File: rtl/uart_slip_decoder.sv
// ---------------------------------------------------------------------------
// uart_slip_decoder
//   Decodes a SLIP-framed byte stream from a UART receiver into an
//   AXI4-Stream packet stream. One payload byte is held back (the "pending"
//   byte) so that tlast can be attached to the final data byte of a frame
//   when the closing END arrives.
//
// Parameters
//   MAX_LEN            maximum payload bytes per frame, 0 = unlimited.
//                      Excess bytes are dropped and the frame marked bad.
// Ports
//   clk                single clock
//   rst                asynchronous active-high reset
//   input_axi_tdata    received byte
//   input_axi_tvalid   received byte valid
//   input_axi_tready   byte accepted on tvalid & tready
//   rx_error           1-cycle UART error pulse, marks current frame bad
//   output_axi_tdata   decoded payload byte
//   output_axi_tvalid  payload valid
//   output_axi_tready  downstream accept
//   output_axi_tlast   last byte of frame
//   output_axi_tuser   frame bad (meaningful with tlast)
//   busy               frame in progress (pending byte held or in ESC state)
//   esc_error          1-cycle pulse: ESC followed by a byte other than DC/DD
//   len_error          1-cycle pulse: byte dropped because of MAX_LEN
// ---------------------------------------------------------------------------
module uart_slip_decoder
   import uart_slip_decoder_pkg::*;
#(
   parameter int unsigned MAX_LEN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] input_axi_tdata,
   input  logic       input_axi_tvalid,
   output logic       input_axi_tready,
   input  logic       rx_error,
   output logic [7:0] output_axi_tdata,
   output logic       output_axi_tvalid,
   input  logic       output_axi_tready,
   output logic       output_axi_tlast,
   output logic       output_axi_tuser,
   output logic       busy,
   output logic       esc_error,
   output logic       len_error
);

   localparam logic [LEN_CNT_W-1:0] MAX_LEN_W    = MAX_LEN[LEN_CNT_W-1:0];
   localparam logic                 LEN_LIMIT_EN = (MAX_LEN != 0);
   localparam logic [LEN_CNT_W-1:0] LEN_SAT      = '1;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e               state_q,      state_d;
   logic [7:0]           pend_data_q,  pend_data_d;
   logic                 pend_valid_q, pend_valid_d;
   logic                 bad_q,        bad_d;
   logic [LEN_CNT_W-1:0] len_cnt_q,    len_cnt_d;
   logic [7:0]           out_data_q,   out_data_d;
   logic                 out_valid_q,  out_valid_d;
   logic                 out_last_q,   out_last_d;
   logic                 out_user_q,   out_user_d;
   logic                 esc_err_q,    esc_err_d;
   logic                 len_err_q,    len_err_d;

   // Decode intermediates
   logic       accept;
   logic       is_end;
   logic       is_data;
   logic [7:0] data_byte;

   // The output register is free either when empty or when it is being
   // drained this very cycle, so an emit on accept can never overwrite a beat.
   assign input_axi_tready = ~out_valid_q | output_axi_tready;
   assign accept           = input_axi_tvalid & input_axi_tready;

   always_comb begin
      state_d      = state_q;
      pend_data_d  = pend_data_q;
      pend_valid_d = pend_valid_q;
      bad_d        = bad_q | rx_error;
      len_cnt_d    = len_cnt_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q & ~output_axi_tready;
      out_last_d   = out_last_q;
      out_user_d   = out_user_q;
      esc_err_d    = 1'b0;
      len_err_d    = 1'b0;
      is_end       = 1'b0;
      is_data      = 1'b0;
      data_byte    = input_axi_tdata;

      if (accept) begin
         // ---- classify the accepted byte ----
         if (state_q == STATE_NORMAL) begin
            case (input_axi_tdata)
               SLIP_END: is_end  = 1'b1;
               SLIP_ESC: state_d = STATE_ESC;
               default:  is_data = 1'b1;
            endcase
         end else begin
            state_d = STATE_NORMAL;
            case (input_axi_tdata)
               SLIP_ESC_END: begin
                  is_data   = 1'b1;
                  data_byte = SLIP_END;
               end
               SLIP_ESC_ESC: begin
                  is_data   = 1'b1;
                  data_byte = SLIP_ESC;
               end
               SLIP_END: begin
                  // Broken escape right before frame close: frame closes bad
                  esc_err_d = 1'b1;
                  bad_d     = 1'b1;
                  is_end    = 1'b1;
               end
               default: begin
                  // Broken escape: keep the raw byte, flag the frame
                  esc_err_d = 1'b1;
                  bad_d     = 1'b1;
                  is_data   = 1'b1;
               end
            endcase
         end

         // ---- frame close ----
         if (is_end) begin
            if (pend_valid_q) begin
               out_data_d   = pend_data_q;
               out_valid_d  = 1'b1;
               out_last_d   = 1'b1;
               // bad_d already folds in rx_error and any escape error
               out_user_d   = bad_d;
               pend_valid_d = 1'b0;
            end
            bad_d     = 1'b0;
            len_cnt_d = '0;
         end

         // ---- payload byte ----
         if (is_data) begin
            if (LEN_LIMIT_EN && (len_cnt_q == MAX_LEN_W)) begin
               bad_d     = 1'b1;
               len_err_d = 1'b1;
            end else begin
               if (pend_valid_q) begin
                  out_data_d  = pend_data_q;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  out_user_d  = 1'b0;
               end
               pend_data_d  = data_byte;
               pend_valid_d = 1'b1;
               if (len_cnt_q != LEN_SAT) begin
                  len_cnt_d = len_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STATE_NORMAL;
         pend_data_q  <= '0;
         pend_valid_q <= 1'b0;
         bad_q        <= 1'b0;
         len_cnt_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_user_q   <= 1'b0;
         esc_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_data_q  <= pend_data_d;
         pend_valid_q <= pend_valid_d;
         bad_q        <= bad_d;
         len_cnt_q    <= len_cnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_user_q   <= out_user_d;
         esc_err_q    <= esc_err_d;
         len_err_q    <= len_err_d;
      end
   end

   assign output_axi_tdata  = out_data_q;
   assign output_axi_tvalid = out_valid_q;
   assign output_axi_tlast  = out_last_q;
   assign output_axi_tuser  = out_user_q;
   assign busy              = pend_valid_q | (state_q == STATE_ESC);
   assign esc_error         = esc_err_q;
   assign len_error         = len_err_q;

endmodule : uart_slip_decoder

// File: tb/tb_uart_slip_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_slip_decoder
//   Directed bench for uart_slip_decoder. dut1 runs with MAX_LEN=0, dut2 with
//   MAX_LEN=2. Expected beats are pushed to per-DUT queues as stimulus is
//   written; monitors pop and compare on every output handshake.
// ---------------------------------------------------------------------------
module tb_uart_slip_decoder;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid1, in_valid2;
   logic       in_ready1, in_ready2;
   logic       rx_err1;
   logic [7:0] out_data1, out_data2;
   logic       out_valid1, out_valid2;
   logic       out_rdy1;
   logic       out_last1, out_last2;
   logic       out_user1, out_user2;
   logic       busy1, busy2;
   logic       esc1, esc2;
   logic       len1, len2;

   beat_t q1[$];
   beat_t q2[$];

   int n_pass  = 0;
   int n_total = 0;
   int esc_cnt1 = 0;
   int len_cnt1 = 0;
   int len_cnt2 = 0;
   int beats1 = 0;
   int beats2 = 0;
   logic rand_en = 1'b0;

   always #5 clk = ~clk;

   uart_slip_decoder #(.MAX_LEN(0)) dut1 (
      .clk               (clk),
      .rst               (rst),
      .input_axi_tdata   (in_data),
      .input_axi_tvalid  (in_valid1),
      .input_axi_tready  (in_ready1),
      .rx_error          (rx_err1),
      .output_axi_tdata  (out_data1),
      .output_axi_tvalid (out_valid1),
      .output_axi_tready (out_rdy1),
      .output_axi_tlast  (out_last1),
      .output_axi_tuser  (out_user1),
      .busy              (busy1),
      .esc_error         (esc1),
      .len_error         (len1)
   );

   uart_slip_decoder #(.MAX_LEN(2)) dut2 (
      .clk               (clk),
      .rst               (rst),
      .input_axi_tdata   (in_data),
      .input_axi_tvalid  (in_valid2),
      .input_axi_tready  (in_ready2),
      .rx_error          (1'b0),
      .output_axi_tdata  (out_data2),
      .output_axi_tvalid (out_valid2),
      .output_axi_tready (1'b1),
      .output_axi_tlast  (out_last2),
      .output_axi_tuser  (out_user2),
      .busy              (busy2),
      .esc_error         (esc2),
      .len_error         (len2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic expect1(input logic [7:0] d, input logic l, input logic u);
      beat_t b;
      b.d = d; b.l = l; b.u = u;
      q1.push_back(b);
   endtask

   task automatic expect2(input logic [7:0] d, input logic l, input logic u);
      beat_t b;
      b.d = d; b.l = l; b.u = u;
      q2.push_back(b);
   endtask

   // Present one byte, wait (bounded) for tready, complete the handshake.
   task automatic send(input int which, input logic [7:0] b);
      int n;
      @(negedge clk);
      in_data = b;
      if (which == 1) in_valid1 = 1'b1;
      else            in_valid2 = 1'b1;
      #1;
      n = 0;
      while (((which == 1) ? in_ready1 : in_ready2) !== 1'b1 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
   endtask

   task automatic wait_drain(input int which, input string tag);
      int n;
      n = 0;
      while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check(tag, (which == 1) ? q1.size() : q2.size(), 0);
   endtask

   // Random downstream backpressure when enabled
   initial begin
      forever begin
         @(negedge clk);
         if (rand_en) out_rdy1 = 1'($urandom_range(0, 1));
      end
   end

   // dut1 monitor: handshake completes at the following posedge
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (esc1 === 1'b1) esc_cnt1++;
         if (len1 === 1'b1) len_cnt1++;
         if (out_valid1 === 1'b1 && out_rdy1 === 1'b1 && rst === 1'b0) begin
            check("dut1_beat_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               beats1++;
               $display("dut1 beat %0d: data=%02h last=%0b user=%0b (exp %02h/%0b/%0b)",
                        beats1, out_data1, out_last1, out_user1, e.d, e.l, e.u);
               check("dut1_tdata", 32'(out_data1), 32'(e.d));
               check("dut1_tlast", 32'(out_last1), 32'(e.l));
               if (e.l) check("dut1_tuser", 32'(out_user1), 32'(e.u));
            end
         end
      end
   end

   // dut2 monitor (downstream always ready)
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (len2 === 1'b1) len_cnt2++;
         if (out_valid2 === 1'b1 && rst === 1'b0) begin
            check("dut2_beat_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
               e = q2.pop_front();
               beats2++;
               $display("dut2 beat %0d: data=%02h last=%0b user=%0b (exp %02h/%0b/%0b)",
                        beats2, out_data2, out_last2, out_user2, e.d, e.l, e.u);
               check("dut2_tdata", 32'(out_data2), 32'(e.d));
               check("dut2_tlast", 32'(out_last2), 32'(e.l));
               if (e.l) check("dut2_tuser", 32'(out_user2), 32'(e.u));
            end
         end
      end
   end

   initial begin
      int esc_before;
      int beats_before;

      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      rx_err1   = 1'b0;
      out_rdy1  = 1'b1;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      check("rst_tvalid", 32'(out_valid1), 32'd0);
      check("rst_tlast",  32'(out_last1),  32'd0);
      check("rst_tuser",  32'(out_user1),  32'd0);
      check("rst_tdata",  32'(out_data1),  32'd0);
      check("rst_busy",   32'(busy1),      32'd0);
      check("rst_esc",    32'(esc1),       32'd0);
      check("rst_len",    32'(len1),       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ---- 1: C0 41 42 43 C0 ----
      expect1(8'h41, 0, 0); expect1(8'h42, 0, 0); expect1(8'h43, 1, 0);
      send(1, 8'hC0); send(1, 8'h41); send(1, 8'h42);
      check("t1_busy_mid", 32'(busy1), 32'd1);
      send(1, 8'h43); send(1, 8'hC0);
      wait_drain(1, "t1_drain");
      check("t1_busy_after", 32'(busy1), 32'd0);

      // ---- 2: 01 DB DC DB DD 02 C0 ----
      expect1(8'h01, 0, 0); expect1(8'hC0, 0, 0); expect1(8'hDB, 0, 0); expect1(8'h02, 1, 0);
      send(1, 8'h01); send(1, 8'hDB);
      check("t2_busy_esc", 32'(busy1), 32'd1);
      send(1, 8'hDC); send(1, 8'hDB); send(1, 8'hDD); send(1, 8'h02); send(1, 8'hC0);
      wait_drain(1, "t2_drain");

      // ---- 3: C0 C0 C0 -> nothing ----
      beats_before = beats1;
      send(1, 8'hC0); send(1, 8'hC0); send(1, 8'hC0);
      repeat (5) @(negedge clk);
      check("t3_no_beats", 32'(beats1 - beats_before), 32'd0);
      check("t3_esc_cnt",  32'(esc_cnt1), 32'd0);
      check("t3_len_cnt",  32'(len_cnt1), 32'd0);

      // ---- 4: 10 DB 55 20 C0, then clean frame 77 C0 ----
      esc_before = esc_cnt1;
      expect1(8'h10, 0, 0); expect1(8'h55, 0, 0); expect1(8'h20, 1, 1);
      send(1, 8'h10); send(1, 8'hDB); send(1, 8'h55); send(1, 8'h20); send(1, 8'hC0);
      wait_drain(1, "t4_drain");
      check("t4_esc_pulses", 32'(esc_cnt1 - esc_before), 32'd1);
      expect1(8'h77, 1, 0);
      send(1, 8'h77); send(1, 8'hC0);
      wait_drain(1, "t4_clean_drain");

      // ---- 4b: ESC then END closes frame bad ----
      expect1(8'h66, 1, 1);
      send(1, 8'h66); send(1, 8'hDB); send(1, 8'hC0);
      wait_drain(1, "t4b_drain");
      check("t4b_esc_pulses", 32'(esc_cnt1 - esc_before), 32'd2);

      // ---- 5: MAX_LEN=2 on dut2: 01 02 03 C0 ----
      expect2(8'h01, 0, 0); expect2(8'h02, 1, 1);
      send(2, 8'h01); send(2, 8'h02); send(2, 8'h03); send(2, 8'hC0);
      wait_drain(2, "t5_drain");
      check("t5_len_pulses", 32'(len_cnt2), 32'd1);
      expect2(8'h09, 0, 0); expect2(8'h0A, 1, 0);
      send(2, 8'h09); send(2, 8'h0A); send(2, 8'hC0);
      wait_drain(2, "t5_clean_drain");
      check("t5_len_pulses_after", 32'(len_cnt2), 32'd1);

      // ---- 6a: backpressure, then random tready and rx_error mid-frame ----
      @(negedge clk);
      out_rdy1 = 1'b0;
      expect1(8'h31, 0, 0); expect1(8'h32, 0, 0); expect1(8'h33, 0, 0);
      expect1(8'h34, 0, 0); expect1(8'h35, 1, 1);
      send(1, 8'h31); send(1, 8'h32);
      @(negedge clk);
      in_data   = 8'h33;
      in_valid1 = 1'b1;
      #1;
      check("t6_in_ready_low", 32'(in_ready1), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("t6_in_ready_held", 32'(in_ready1), 32'd0);
      check("t6_out_valid_held", 32'(out_valid1), 32'd1);
      check("t6_out_data_held", 32'(out_data1), 32'h31);
      rand_en = 1'b1;
      send(1, 8'h33); send(1, 8'h34);
      @(negedge clk);
      rx_err1 = 1'b1;
      @(negedge clk);
      rx_err1 = 1'b0;
      send(1, 8'h35); send(1, 8'hC0);
      wait_drain(1, "t6_drain");
      rand_en = 1'b0;
      @(negedge clk);
      out_rdy1 = 1'b1;

      // ---- 6b: reset mid-frame drops the pending byte ----
      expect1(8'h61, 0, 0); expect1(8'h62, 0, 0);
      send(1, 8'h61); send(1, 8'h62); send(1, 8'h63);
      wait_drain(1, "t6b_pre_drain");
      check("t6b_busy_pre", 32'(busy1), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6b_rst_tvalid", 32'(out_valid1), 32'd0);
      check("t6b_rst_busy",   32'(busy1),      32'd0);
      check("t6b_rst_tlast",  32'(out_last1),  32'd0);
      check("t6b_rst_tdata",  32'(out_data1),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      expect1(8'h70, 1, 0);
      send(1, 8'h70); send(1, 8'hC0);
      wait_drain(1, "t6b_post_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_uart_slip_decoder
